// File: rtl/seven_segment_counter_mux_if.sv
// Control and display signal bundle for seven_segment_counter_mux.
// The master side drives the count controls; the slave side is the counter/display block.
interface seven_segment_counter_mux_if #(
    parameter int DIGITS = 2
);
    logic              en;
    logic              up;
    logic              clear;
    logic [6:0]        segments;
    logic [DIGITS-1:0] digit_sel;
    logic              tick;
    logic              rollover;

    modport master (
        output en, up, clear,
        input  segments, digit_sel, tick, rollover
    );

    modport slave (
        input  en, up, clear,
        output segments, digit_sel, tick, rollover
    );
endinterface

// File: rtl/seven_segment_counter_mux.sv
// Multi-digit up/down tick counter with time-multiplexed seven-segment drive.
// Define SEVEN_SEG_HEX_EN for hexadecimal digits (0..F); default is BCD (0..9).
module seven_segment_counter_mux #(
    parameter int MAX_COUNT = 10_000_000,
    parameter int DIGITS    = 2,
    parameter int MUX_COUNT = 1000
) (
    input logic                        clk,
    input logic                        rst,
    seven_segment_counter_mux_if.slave bus
);
    localparam int PRE_W = $clog2(MAX_COUNT);
    localparam int SCN_W = (MUX_COUNT > 1) ? $clog2(MUX_COUNT) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VAL_W = 4 * DIGITS;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(MAX_COUNT - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
    localparam logic [SCN_W-1:0] SCN_LAST = SCN_W'(MUX_COUNT - 1);
    localparam logic [SCN_W-1:0] SCN_ONE  = SCN_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
`ifdef SEVEN_SEG_HEX_EN
    localparam logic [3:0] NIB_LAST = 4'hF;
`else
    localparam logic [3:0] NIB_LAST = 4'h9;
`endif

    // Glyphs outside the configured base decode to blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
`ifdef SEVEN_SEG_HEX_EN
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
`endif
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [PRE_W-1:0]  pre_r;
    logic [VAL_W-1:0]  value_r;
    logic [SCN_W-1:0]  scn_r;
    logic [IDX_W-1:0]  idx_r;
    logic [6:0]        segments_r;
    logic [DIGITS-1:0] digit_sel_r;
    logic              tick_r;
    logic              rollover_r;

    logic [VAL_W-1:0]  value_next_s;
    logic              carry_s;
    logic              pre_wrap_s;
    logic              scn_wrap_s;
    logic [IDX_W-1:0]  idx_next_s;
    logic [3:0]        sel_nib_s;
    logic [DIGITS-1:0] onehot_s;

    // Ripple increment/decrement of the nibble vector; carry_s left set means every digit wrapped.
    always_comb begin
        value_next_s = value_r;
        carry_s      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry_s) begin
                if (bus.up) begin
                    if (value_r[i*4 +: 4] == NIB_LAST) begin
                        value_next_s[i*4 +: 4] = 4'h0;
                    end else begin
                        value_next_s[i*4 +: 4] = value_r[i*4 +: 4] + 4'h1;
                        carry_s                = 1'b0;
                    end
                end else begin
                    if (value_r[i*4 +: 4] == 4'h0) begin
                        value_next_s[i*4 +: 4] = NIB_LAST;
                    end else begin
                        value_next_s[i*4 +: 4] = value_r[i*4 +: 4] - 4'h1;
                        carry_s                = 1'b0;
                    end
                end
            end else begin
                value_next_s[i*4 +: 4] = value_r[i*4 +: 4];
            end
        end
    end

    // Scan sequencing: next digit index plus its nibble and one-hot select.
    always_comb begin
        pre_wrap_s = (pre_r == PRE_LAST);
        scn_wrap_s = (scn_r == SCN_LAST);
        if (!scn_wrap_s) begin
            idx_next_s = idx_r;
        end else if (idx_r == IDX_LAST) begin
            idx_next_s = {IDX_W{1'b0}};
        end else begin
            idx_next_s = idx_r + IDX_ONE;
        end
        sel_nib_s = 4'h0;
        onehot_s  = {DIGITS{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            sel_nib_s   = (IDX_W'(i) == idx_next_s) ? value_r[i*4 +: 4] : sel_nib_s;
            onehot_s[i] = (IDX_W'(i) == idx_next_s);
        end
    end

    // Prescaler, count value and tick/rollover pulses; clear outranks a coincident tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r      <= {PRE_W{1'b0}};
            value_r    <= {VAL_W{1'b0}};
            tick_r     <= 1'b0;
            rollover_r <= 1'b0;
        end else if (bus.clear) begin
            pre_r      <= {PRE_W{1'b0}};
            value_r    <= {VAL_W{1'b0}};
            tick_r     <= 1'b0;
            rollover_r <= 1'b0;
        end else if (bus.en && pre_wrap_s) begin
            pre_r      <= {PRE_W{1'b0}};
            value_r    <= value_next_s;
            tick_r     <= 1'b1;
            rollover_r <= carry_s;
        end else if (bus.en) begin
            pre_r      <= pre_r + PRE_ONE;
            tick_r     <= 1'b0;
            rollover_r <= 1'b0;
        end else begin
            tick_r     <= 1'b0;
            rollover_r <= 1'b0;
        end
    end

    // Free-running scan; select and glyph load on the same edge so they never skew.
    always_ff @(posedge clk) begin
        if (rst) begin
            scn_r       <= {SCN_W{1'b0}};
            idx_r       <= {IDX_W{1'b0}};
            digit_sel_r <= DIGITS'(1);
            segments_r  <= 7'h3F;
        end else begin
            scn_r       <= scn_wrap_s ? {SCN_W{1'b0}} : (scn_r + SCN_ONE);
            idx_r       <= idx_next_s;
            digit_sel_r <= onehot_s;
            segments_r  <= seg_decode(sel_nib_s);
        end
    end

    assign bus.segments  = segments_r;
    assign bus.digit_sel = digit_sel_r;
    assign bus.tick      = tick_r;
    assign bus.rollover  = rollover_r;
endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Self-checking bench: directed scenarios plus random control traffic against an integer-valued model.
module tb_seven_segment_counter_mux;
    localparam int MAXC = 4;
    localparam int D    = 2;
    localparam int MUXC = 2;
`ifdef SEVEN_SEG_HEX_EN
    localparam int B = 16;
    localparam logic [6:0] G_LAST = 7'h71;
    localparam logic [6:0] G_PREV = 7'h79;
`else
    localparam int B = 10;
    localparam logic [6:0] G_LAST = 7'h6F;
    localparam logic [6:0] G_PREV = 7'h7F;
`endif
    localparam int N = B ** D;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seven_segment_counter_mux_if #(.DIGITS(D)) bus ();
    seven_segment_counter_mux #(.MAX_COUNT(MAXC), .DIGITS(D), .MUX_COUNT(MUXC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int m_val, m_pre, m_cyc;
    logic m_tick, m_roll;
    logic [6:0] m_seg;
    logic [D-1:0] m_sel;

    function automatic logic [6:0] glyph(int d);
        case (d)
            0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
            4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
            8: return 7'h7F;  9: return 7'h6F; 10: return 7'h77; 11: return 7'h7C;
            12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; 15: return 7'h71;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [10:0] obs_vec();
        return {bus.segments, bus.digit_sel, bus.tick, bus.rollover};
    endfunction

    function automatic logic [10:0] exp_vec();
        return {m_seg, m_sel, m_tick, m_roll};
    endfunction

    // Advance the model by one clock edge using the inputs currently applied, then sample.
    task automatic step();
        int idx;
        if (rst) begin
            m_val = 0; m_pre = 0; m_cyc = 0; m_tick = 1'b0; m_roll = 1'b0;
            m_sel = D'(1); m_seg = 7'h3F;
        end else begin
            m_cyc++;
            idx   = (m_cyc / MUXC) % D;
            m_sel = D'(1) << idx;
            m_seg = glyph((m_val / (B ** idx)) % B);
            m_tick = 1'b0; m_roll = 1'b0;
            if (bus.clear) begin
                m_val = 0; m_pre = 0;
            end else if (bus.en) begin
                if (m_pre == MAXC - 1) begin
                    m_pre = 0; m_tick = 1'b1;
                    if (bus.up) begin
                        m_roll = (m_val == N - 1); m_val = (m_val + 1) % N;
                    end else begin
                        m_roll = (m_val == 0); m_val = (m_val + N - 1) % N;
                    end
                end else begin
                    m_pre++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Pause counting and collect the glyph shown on each digit over one full scan.
    task automatic show(output logic [6:0] d0, output logic [6:0] d1);
        bus.en = 1'b0; bus.clear = 1'b0;
        d0 = 7'bx; d1 = 7'bx;
        for (int k = 0; k < 2 * MUXC * D; k++) begin
            step();
            if (bus.digit_sel == 2'b01) d0 = bus.segments;
            else if (bus.digit_sel == 2'b10) d1 = bus.segments;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; bus.en = 1'b0; bus.up = 1'b1; bus.clear = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [D-1:0] want;
        rst = 1'b1; bus.en = 1'b1; bus.up = 1'b0; bus.clear = 1'b1;
        step(); step();
        checks++;
        if (bus.segments !== 7'h3F || bus.digit_sel !== 2'b01 || bus.tick !== 1'b0 || bus.rollover !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got seg=%h sel=%b tick=%b roll=%b want seg=3f sel=01 tick=0 roll=0",
                     bus.segments, bus.digit_sel, bus.tick, bus.rollover);
        end
        rst = 1'b0; bus.en = 1'b0; bus.clear = 1'b0; bus.up = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            want = (((k / 2) % 2) == 1) ? 2'b10 : 2'b01;
            checks++;
            if (bus.digit_sel !== want) begin
                errors++;
                $display("FAIL reset_scan k=%0d got sel=%b want %b", k, bus.digit_sel, want);
            end
        end
    endtask

    task automatic test_up_count();
        int last, nt;
        logic [6:0] d0, d1;
        do_reset();
        bus.en = 1'b1; bus.up = 1'b1;
        last = -1; nt = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL up_count_model cyc=%0d got=%h want=%h", m_cyc, obs_vec(), exp_vec());
            end
            if (bus.tick === 1'b1) begin
                nt++;
                checks++;
                if (last >= 0 && k - last != 4) begin
                    errors++;
                    $display("FAIL up_count_spacing got=%0d want=4", k - last);
                end
                last = k;
            end
            checks++;
            if (bus.rollover !== 1'b0) begin
                errors++;
                $display("FAIL up_count_rollover k=%0d got=%b want=0", k, bus.rollover);
            end
        end
        checks++;
        if (nt != 10) begin
            errors++;
            $display("FAIL up_count_ticks got=%0d want=10", nt);
        end
        show(d0, d1);
        checks++;
        if (d0 !== 7'h3F || d1 !== 7'h06) begin
            errors++;
            $display("FAIL up_count_display got d1=%h d0=%h want d1=06 d0=3f", d1, d0);
        end
    endtask

    task automatic test_up_wrap();
        int nroll;
        logic [6:0] d0, d1;
        bus.en = 1'b1; bus.up = 1'b1;
        for (int k = 0; k < (N - 1 - 10) * MAXC; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL up_wrap_model cyc=%0d got=%h want=%h", m_cyc, obs_vec(), exp_vec());
            end
        end
        show(d0, d1);
        checks++;
        if (d0 !== G_LAST || d1 !== G_LAST) begin
            errors++;
            $display("FAIL up_wrap_full got d1=%h d0=%h want %h", d1, d0, G_LAST);
        end
        bus.en = 1'b1; nroll = 0;
        for (int k = 0; k < MAXC + 1; k++) begin
            step();
            if (bus.rollover === 1'b1) nroll++;
            checks++;
            if (bus.rollover !== bus.tick || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL up_wrap_pulse got tick=%b roll=%b vec=%h want=%h", bus.tick, bus.rollover, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (nroll != 1) begin
            errors++;
            $display("FAIL up_wrap_count got=%0d want=1", nroll);
        end
        show(d0, d1);
        checks++;
        if (d0 !== 7'h3F || d1 !== 7'h3F) begin
            errors++;
            $display("FAIL up_wrap_zero got d1=%h d0=%h want 3f", d1, d0);
        end
    endtask

    task automatic test_down_wrap();
        logic [6:0] d0, d1;
        do_reset();
        bus.en = 1'b1; bus.up = 1'b0;
        for (int k = 1; k <= MAXC; k++) step();
        checks++;
        if (bus.tick !== 1'b1 || bus.rollover !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap_pulse got tick=%b roll=%b want 1 1", bus.tick, bus.rollover);
        end
        show(d0, d1);
        checks++;
        if (d0 !== G_LAST || d1 !== G_LAST) begin
            errors++;
            $display("FAIL down_wrap_full got d1=%h d0=%h want %h", d1, d0, G_LAST);
        end
        bus.en = 1'b1;
        for (int k = 1; k <= MAXC; k++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL down_wrap_model cyc=%0d got=%h want=%h", m_cyc, obs_vec(), exp_vec());
            end
        end
        show(d0, d1);
        checks++;
        if (d0 !== G_PREV || d1 !== G_LAST) begin
            errors++;
            $display("FAIL down_wrap_next got d1=%h d0=%h want d1=%h d0=%h", d1, d0, G_LAST, G_PREV);
        end
    endtask

    task automatic test_pause_clear();
        logic [6:0] d0, d1;
        do_reset();
        bus.en = 1'b1; bus.up = 1'b1;
        step(); step();
        bus.en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (bus.tick !== 1'b0) begin
                errors++;
                $display("FAIL pause_tick k=%0d got=%b want=0", k, bus.tick);
            end
        end
        bus.en = 1'b1;
        step();
        checks++;
        if (bus.tick !== 1'b0) begin
            errors++;
            $display("FAIL resume_early got=%b want=0", bus.tick);
        end
        step();
        checks++;
        if (bus.tick !== 1'b1) begin
            errors++;
            $display("FAIL resume_tick got=%b want=1", bus.tick);
        end
        step(); step(); step();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        checks++;
        if (bus.tick !== 1'b0 || bus.rollover !== 1'b0 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL clear_tick got tick=%b roll=%b vec=%h want tick=0 roll=0 vec=%h",
                     bus.tick, bus.rollover, obs_vec(), exp_vec());
        end
        show(d0, d1);
        checks++;
        if (d0 !== 7'h3F || d1 !== 7'h3F || bus.digit_sel !== m_sel) begin
            errors++;
            $display("FAIL clear_value got d1=%h d0=%h sel=%b want 3f 3f sel=%b", d1, d0, bus.digit_sel, m_sel);
        end
    endtask

`ifdef SEVEN_SEG_HEX_EN
    task automatic test_hex();
        logic [6:0] d0, d1;
        do_reset();
        bus.en = 1'b1; bus.up = 1'b1;
        for (int k = 0; k < 10 * MAXC; k++) step();
        show(d0, d1);
        checks++;
        if (d0 !== 7'h77 || d1 !== 7'h3F) begin
            errors++;
            $display("FAIL hex_0a got d1=%h d0=%h want d1=3f d0=77", d1, d0);
        end
        bus.en = 1'b1;
        for (int k = 0; k < 6 * MAXC; k++) step();
        show(d0, d1);
        checks++;
        if (d0 !== 7'h3F || d1 !== 7'h06) begin
            errors++;
            $display("FAIL hex_10 got d1=%h d0=%h want d1=06 d0=3f", d1, d0);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 800; k++) begin
            rst       = ($urandom_range(0, 99) == 0);
            bus.en    = ($urandom_range(0, 3) != 0);
            bus.up    = $urandom_range(0, 1) == 1;
            bus.clear = ($urandom_range(0, 29) == 0);
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.up = 1'b1; bus.clear = 1'b0;
        test_reset();
        test_up_count();
        test_up_wrap();
        test_down_wrap();
        test_pause_clear();
`ifdef SEVEN_SEG_HEX_EN
        test_hex();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
